npu_mem_arbiter: RTL and testbench

- Shares the single external memory port between NUM_REQ NPU masters: the NPU controller's command fetch/result store and the accelerator data movers.
- Round-robin single-beat arbitration with an optional per-requester lock, so a master can hold the port across several accesses.
- Per-access timeout protects the fabric from a memory that never answers.
- Sits between the masters and the memory pins. The memory side uses the same strobe and ready signalling the NPU controller drives today.

---
 rtl/npu_mem_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_npu_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_mem_arbiter.sv
// Shares one external memory port between NUM_REQ NPU masters: round-robin single-beat
// grants, optional per-requester lock between accesses, and a per-access timeout.
module npu_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 255,
    parameter int ID_W       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          resp_err,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_data_out,
    output logic                          mem_we,
    output logic                          mem_re,
    input  logic [DATA_WIDTH-1:0]         mem_data_in,
    input  logic                          mem_mem_ready,
    output logic                          busy,
    output logic [ID_W-1:0]               owner_id
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    // The counter only needs to reach TIMEOUT-1: the TIMEOUT-th idle cycle aborts directly.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]            state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       owner_q, owner_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [DATA_WIDTH-1:0] mdata_q, mdata_d;
    logic                  mwe_q, mwe_d;
    logic                  mre_q, mre_d;
    logic                  busy_q, busy_d;

    logic                  any_req;
    logic [ID_W-1:0]       rr_pick;
    logic [ID_W-1:0]       scan;
    logic                  own_req;
    logic                  own_lock;
    logic [NUM_REQ-1:0]    own_onehot;
    logic                  issue;
    logic [ID_W-1:0]       issue_sel;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_we;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] i);
        if (i == ID_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return i + ID_W'(1);
    endfunction

    // First asserted request at or after the rr pointer, wrapping modulo NUM_REQ.
    always_comb begin
        any_req = 1'b0;
        rr_pick = '0;
        scan    = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_req && req[scan]) begin
                any_req = 1'b1;
                rr_pick = scan;
            end
            scan = wrap_inc(scan);
        end
    end

    always_comb begin
        own_req    = 1'b0;
        own_lock   = 1'b0;
        own_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == ID_W'(i)) begin
                own_req       = req[i];
                own_lock      = lock[i];
                own_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        ack_d     = '0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        maddr_d   = maddr_q;
        mdata_d   = mdata_q;
        mwe_d     = mwe_q;
        mre_d     = mre_q;
        issue     = 1'b0;
        issue_sel = owner_q;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    issue     = 1'b1;
                    issue_sel = rr_pick;
                end
            end
            S_ACCESS: begin
                // A ready arriving on the timeout cycle still counts as success.
                if (mem_mem_ready || (cnt_q == CNT_LAST)) begin
                    ack_d = own_onehot;
                    mwe_d = 1'b0;
                    mre_d = 1'b0;
                    cnt_d = '0;
                    if (mem_mem_ready) begin
                        if (mre_q) begin
                            rdata_d = mem_data_in;
                        end
                        if (own_lock) begin
                            state_d = S_LOCKED;
                        end else begin
                            state_d = S_IDLE;
                            ptr_d   = wrap_inc(owner_q);
                        end
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = S_IDLE;
                        ptr_d   = wrap_inc(owner_q);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOCKED: begin
                if (own_req) begin
                    issue     = 1'b1;
                    issue_sel = owner_q;
                end else if (!own_lock) begin
                    state_d = S_IDLE;
                    ptr_d   = wrap_inc(owner_q);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        for (int i = 0; i < NUM_REQ; i++) begin
            if (issue_sel == ID_W'(i)) begin
                sel_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_we    = we[i];
            end
        end

        if (issue) begin
            owner_d = issue_sel;
            maddr_d = sel_addr;
            mdata_d = sel_wdata;
            mwe_d   = sel_we;
            mre_d   = !sel_we;
            cnt_d   = '0;
            state_d = S_ACCESS;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            maddr_q <= '0;
            mdata_q <= '0;
            mwe_q   <= 1'b0;
            mre_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            maddr_q <= maddr_d;
            mdata_q <= mdata_d;
            mwe_q   <= mwe_d;
            mre_q   <= mre_d;
            busy_q  <= busy_d;
        end
    end

    assign ack          = ack_q;
    assign resp_err     = err_q;
    assign rdata        = rdata_q;
    assign mem_addr     = maddr_q;
    assign mem_data_out = mdata_q;
    assign mem_we       = mwe_q;
    assign mem_re       = mre_q;
    assign busy         = busy_q;
    assign owner_id     = owner_q;

endmodule

// File: tb/tb_npu_mem_arbiter.sv
// Bench for npu_mem_arbiter: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_npu_mem_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TO  = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, lock, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    ack;
    logic            resp_err;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_data_out;
    logic            mem_we, mem_re;
    logic [DW-1:0]   mem_data_in;
    logic            mem_mem_ready;
    logic            busy;
    logic [IDW-1:0]  owner_id;

    always #5 clk = ~clk;

    npu_mem_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N), .TIMEOUT(TO), .ID_W(IDW)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .resp_err(resp_err), .rdata(rdata), .mem_addr(mem_addr),
        .mem_data_out(mem_data_out), .mem_we(mem_we), .mem_re(mem_re),
        .mem_data_in(mem_data_in), .mem_mem_ready(mem_mem_ready), .busy(busy),
        .owner_id(owner_id)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the port, whether an access is in flight, how long it has run.
    int             m_owner, m_ptr, m_elapsed;
    bit             m_active, m_held, m_read;
    logic [N-1:0]   e_ack;
    logic           e_err, e_we, e_re, e_busy;
    logic [DW-1:0]  e_rdata, e_dout;
    logic [AW-1:0]  e_addr;
    logic [IDW-1:0] e_oid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int rr_first(input logic [N-1:0] r, input int from);
        for (int k = 0; k < N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int nxt;
        if (rst) begin
            m_owner = 0; m_ptr = 0; m_elapsed = 0;
            m_active = 0; m_held = 0; m_read = 0;
            e_ack = '0; e_err = 0; e_we = 0; e_re = 0; e_busy = 0;
            e_rdata = '0; e_dout = '0; e_addr = '0; e_oid = '0;
            return;
        end
        e_ack = '0;
        e_err = 1'b0;
        if (m_active) begin
            m_elapsed++;
            if (mem_mem_ready || m_elapsed == TO) begin
                e_ack[m_owner] = 1'b1;
                e_we = 1'b0;
                e_re = 1'b0;
                m_active = 0;
                if (!mem_mem_ready) begin
                    e_err = 1'b1;
                    e_rdata = '0;
                    m_held = 0;
                end else begin
                    if (m_read) e_rdata = mem_data_in;
                    m_held = lock[m_owner];
                end
                if (!m_held) m_ptr = (m_owner + 1) % N;
            end
        end else begin
            nxt = -1;
            if (m_held) begin
                if (req[m_owner]) nxt = m_owner;
                else if (!lock[m_owner]) begin
                    m_held = 0;
                    m_ptr = (m_owner + 1) % N;
                end
            end else begin
                nxt = rr_first(req, m_ptr);
            end
            if (nxt >= 0) begin
                m_owner = nxt;
                m_active = 1;
                m_held = 0;
                m_elapsed = 0;
                m_read = !we[nxt];
                e_addr = addr[nxt*AW +: AW];
                e_dout = wdata[nxt*DW +: DW];
                e_we = we[nxt];
                e_re = !we[nxt];
                e_oid = IDW'(nxt);
            end
        end
        e_busy = m_active || m_held;
    endtask

    task automatic compare_all();
        chk("ack", ack, e_ack);
        chk("resp_err", resp_err, e_err);
        chk("rdata", rdata, e_rdata);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_data_out", mem_data_out, e_dout);
        chk("mem_we", mem_we, e_we);
        chk("mem_re", mem_re, e_re);
        chk("busy", busy, e_busy);
        chk("owner_id", owner_id, e_oid);
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_req(input int i, input bit r, input bit w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = r;
        we[i] = w;
        addr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[5];
        order = '{0, 1, 2, 3, 0};
        rst = 1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        mem_data_in = '0; mem_mem_ready = 0;
        cyc(); cyc();
        chk("reset_ack", ack, 0);
        chk("reset_busy", busy, 0);
        chk("reset_re", mem_re, 0);
        chk("reset_owner", owner_id, 0);
        rst = 0;

        // Single read, ready on the third ACCESS cycle.
        set_req(0, 1, 0, 32'h100, 0);
        cyc(); chk("t1_re_c1", mem_re, 1); chk("t1_addr", mem_addr, 32'h100);
        cyc(); chk("t1_re_c2", mem_re, 1);
        cyc(); chk("t1_re_c3", mem_re, 1);
        mem_mem_ready = 1; mem_data_in = 32'hDEADBEEF;
        cyc();
        chk("t1_ack", ack, 4'b0001); chk("t1_rdata", rdata, 32'hDEADBEEF);
        chk("t1_err", resp_err, 0); chk("t1_re_off", mem_re, 0);
        req[0] = 0; mem_mem_ready = 0;
        cyc(); chk("t1_busy", busy, 0);

        // All four writing, memory always ready.
        rst = 1; cyc(); rst = 0;
        for (int i = 0; i < N; i++) set_req(i, 1, 1, 32'h200 + 4*i, 32'hA0000000 + i);
        mem_mem_ready = 1;
        for (int g = 0; g < 5; g++) begin
            cyc();
            chk("t2_owner", owner_id, order[g]);
            chk("t2_we", mem_we, 1);
            chk("t2_dout", mem_data_out, 32'hA0000000 + order[g]);
            cyc();
            chk("t2_ack", ack, 4'b0001 << order[g]);
        end
        req = '0; mem_mem_ready = 0;
        cyc();

        // Locked burst of three writes by requester 0 while requester 2 waits.
        rst = 1; cyc(); rst = 0;
        set_req(0, 1, 1, 32'h10, 32'h1); lock[0] = 1;
        set_req(2, 1, 1, 32'h300, 32'h3);
        mem_mem_ready = 1;
        for (int w = 0; w < 3; w++) begin
            cyc();
            chk("t3_owner", owner_id, 0);
            chk("t3_addr", mem_addr, 32'h10 + 4*w);
            cyc();
            chk("t3_ack", ack, 4'b0001);
            if (w < 2) addr[0 +: AW] = 32'h14 + 4*w;
        end
        req[0] = 0; lock[0] = 0;
        cyc(); chk("t3_rel_ack", ack, 0); chk("t3_rel_busy", busy, 0);
        cyc(); chk("t3_owner2", owner_id, 2);
        cyc(); chk("t3_ack2", ack, 4'b0100);
        req[2] = 0; mem_mem_ready = 0;
        cyc();

        // Ready arrives on the timeout cycle: success.
        rst = 1; cyc(); rst = 0;
        set_req(0, 1, 0, 32'h400, 0);
        for (int c = 0; c < 4; c++) begin
            cyc(); chk("t6_re", mem_re, 1);
        end
        mem_mem_ready = 1; mem_data_in = 32'h12345678;
        cyc();
        chk("t6_ack", ack, 4'b0001); chk("t6_err", resp_err, 0);
        chk("t6_rdata", rdata, 32'h12345678);
        req[0] = 0; mem_mem_ready = 0; mem_data_in = 0;

        // Timeout on requester 1, then pending requester 3 is served.
        set_req(1, 1, 0, 32'h500, 0);
        set_req(3, 1, 1, 32'h600, 32'h66);
        for (int c = 0; c < 4; c++) begin
            cyc(); chk("t4_re", mem_re, 1); chk("t4_owner", owner_id, 1);
        end
        cyc();
        chk("t4_ack", ack, 4'b0010); chk("t4_err", resp_err, 1);
        chk("t4_rdata", rdata, 0); chk("t4_re_off", mem_re, 0);
        req[1] = 0;
        cyc(); chk("t4_next_owner", owner_id, 3); chk("t4_next_we", mem_we, 1);
        mem_mem_ready = 1;
        cyc(); chk("t4_next_ack", ack, 4'b1000); chk("t4_next_err", resp_err, 0);
        req[3] = 0; mem_mem_ready = 0;
        cyc();

        // Reset during the second ACCESS cycle.
        set_req(2, 1, 0, 32'h700, 0);
        cyc(); chk("t5_owner", owner_id, 2);
        cyc(); chk("t5_re", mem_re, 1);
        rst = 1;
        cyc();
        chk("t5_re_off", mem_re, 0); chk("t5_we_off", mem_we, 0);
        chk("t5_ack", ack, 0); chk("t5_busy", busy, 0); chk("t5_owner_rst", owner_id, 0);
        rst = 0; req[2] = 0;
        set_req(3, 1, 0, 32'h800, 0);
        cyc(); chk("t5_owner3", owner_id, 3); chk("t5_addr3", mem_addr, 32'h800);
        mem_mem_ready = 1; mem_data_in = 32'hCAFE0003;
        cyc(); chk("t5_ack3", ack, 4'b1000); chk("t5_rdata3", rdata, 32'hCAFE0003);
        req[3] = 0; mem_mem_ready = 0;

        // Randomized traffic against the model.
        rst = 1; cyc(); rst = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && e_ack[i]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(i, 1, 1'($urandom_range(0, 1)), $urandom, $urandom);
                    else
                        req[i] = 0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    set_req(i, 1, 1'($urandom_range(0, 1)), $urandom, $urandom);
                end
                if ($urandom_range(0, 7) == 0) lock[i] = !lock[i];
            end
            mem_mem_ready = ($urandom_range(0, 99) < 35);
            mem_data_in = $urandom;
            rst = ($urandom_range(0, 999) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
